// File: rtl/wallace_mac_acc.sv
// Accumulates a programmed number of 32-bit unsigned multiplier products into an
// ACC_W-bit sum with a sticky overflow flag, delivered on a valid/ready handshake.
module wallace_mac_acc #(
   parameter int ACC_W = 40,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   input  logic             prod_valid,
   input  logic [31:0]      prod,
   output logic             prod_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] result,
   output logic             ovf,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [ACC_W-1:0]   acc_reg, acc_next;
   logic               ovf_reg, ovf_next;
   logic [LEN_W-1:0]   cnt_reg, cnt_next;
   logic [LEN_W-1:0]   len_reg, len_next;

   // One extra bit captures the carry-out that feeds the sticky overflow flag.
   logic [ACC_W:0]     sum_ext;
   logic               last_prod;

   assign sum_ext   = {1'b0, acc_reg} + {{(ACC_W - 31){1'b0}}, prod};
   assign last_prod = (cnt_reg == (len_reg - LEN_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         ovf_reg   <= 1'b0;
         cnt_reg   <= '0;
         len_reg   <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         ovf_reg   <= ovf_next;
         cnt_reg   <= cnt_next;
         len_reg   <= len_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      ovf_next   = ovf_reg;
      cnt_next   = cnt_reg;
      len_next   = len_reg;
      prod_ready = 1'b0;
      res_valid  = 1'b0;

      case (state_reg)
         IDLE: begin
            // abort outranks start so a simultaneous request is dropped
            if (start && !abort) begin
               acc_next   = '0;
               ovf_next   = 1'b0;
               cnt_next   = '0;
               len_next   = len;
               state_next = (len == '0) ? DONE : ACC;
            end
         end

         ACC: begin
            prod_ready = !abort;
            if (abort) begin
               state_next = IDLE;
            end else if (prod_valid) begin
               acc_next = sum_ext[ACC_W-1:0];
               ovf_next = ovf_reg | sum_ext[ACC_W];
               cnt_next = cnt_reg + LEN_W'(1);
               if (last_prod) begin
                  state_next = DONE;
               end
            end
         end

         DONE: begin
            res_valid = 1'b1;
            if (abort || res_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // result follows the accumulator at all times; res_valid is what qualifies it
   assign result = acc_reg;
   assign ovf    = ovf_reg;
   assign busy   = (state_reg != IDLE);

endmodule
